// File: rtl/tflaf_mse_monitor.sv
// tflaf_mse_monitor: windowed mean-square-error monitor for the TFLAF error stream.
// Each error sample is squared and summed over back-to-back windows of 2^LOG2_WIN
// accepted samples. One rounded, saturated Q(QP) MSE value is produced per window
// and is offered through a one-entry valid/ready output buffer.
module tflaf_mse_monitor #(
  parameter int WIDTH    = 16,
  parameter int QP       = 12,
  parameter int LOG2_WIN = 8,
  parameter int SKIP     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    err_valid,
  input  logic signed [WIDTH-1:0] error_in,
  output logic [WIDTH-1:0]        mse_out,
  output logic                    mse_sat,
  output logic                    mse_valid,
  input  logic                    mse_ready,
  output logic                    busy,
  output logic                    overrun
);

  // The accumulator is wide enough for a full window of maximum squares, so it never wraps.
  localparam int AW = 2*WIDTH + LOG2_WIN;
  localparam int SH = LOG2_WIN + QP;
  localparam logic [7:0]  SKIP_LAST = 8'(SKIP - 1);
  localparam logic [AW:0] RND_HALF  = {{AW{1'b0}}, 1'b1} << (SH - 1);

  typedef enum logic [1:0] {IDLE, SKIPPING, ACCUM, STOPPING} state_t;

  state_t state_reg, state_next;

  logic [7:0]          skip_cnt_reg;
  logic [LOG2_WIN-1:0] win_cnt_reg;
  logic                start_accept;
  logic                take_sample;
  logic                skip_sample;
  logic                win_last;
  logic                win_first;

  // Pipeline stage 1: registered sample with its window tags
  logic                    s1_valid_reg;
  logic signed [WIDTH-1:0] s1_err_reg;
  logic                    s1_first_reg;
  logic                    s1_last_reg;

  // Pipeline stage 2: registered square with its window tags
  logic                    s2_valid_reg;
  logic [2*WIDTH-1:0]      s2_sq_reg;
  logic                    s2_first_reg;
  logic                    s2_last_reg;
  logic signed [2*WIDTH-1:0] prod;

  // Stage 3: accumulator and window-complete flag
  logic [AW-1:0] acc_reg;
  logic          done_reg;

  // Result rounding and saturation
  logic [AW:0]      rnd_sum;
  logic [AW:0]      rnd_shift;
  logic             res_sat;
  logic [WIDTH-1:0] res_val;
  logic             load_ok;

  // Output buffer
  logic [WIDTH-1:0] mse_out_reg;
  logic             mse_sat_reg;
  logic             mse_valid_reg;
  logic             overrun_reg;

  assign win_last  = &win_cnt_reg;
  assign win_first = (win_cnt_reg == '0);

  // Next-state logic: decides which samples are skipped, accumulated or ignored
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    take_sample  = 1'b0;
    skip_sample  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          if (SKIP == 0) state_next = ACCUM;
          else           state_next = SKIPPING;
        end
      end
      SKIPPING: begin
        if (stop) begin
          state_next = IDLE;
        end else if (err_valid) begin
          skip_sample = 1'b1;
          if (skip_cnt_reg == SKIP_LAST) state_next = ACCUM;
        end
      end
      ACCUM: begin
        take_sample = err_valid;
        if (stop) state_next = STOPPING;
      end
      STOPPING: begin
        take_sample = err_valid;
        if (err_valid && win_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Skip and window counters; both restart on an accepted start
  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      skip_cnt_reg <= '0;
      win_cnt_reg  <= '0;
    end else begin
      if (skip_sample) skip_cnt_reg <= skip_cnt_reg + 8'd1;
      if (take_sample) win_cnt_reg  <= win_cnt_reg + 1'b1;
    end
  end

  // Stage 1: capture the accepted sample and whether it opens or closes a window
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= '0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= take_sample;
      s1_err_reg   <= error_in;
      s1_first_reg <= take_sample && win_first;
      s1_last_reg  <= take_sample && win_last;
    end
  end

  assign prod = s1_err_reg * s1_err_reg;

  // Stage 2: register the full-precision square (always non-negative)
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_sq_reg    <= '0;
      s2_first_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_sq_reg    <= prod;
      s2_first_reg <= s1_first_reg;
      s2_last_reg  <= s1_last_reg;
    end
  end

  // Stage 3: the first square of a window loads the accumulator, the rest add to it
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= s2_valid_reg && s2_last_reg;
      if (s2_valid_reg) begin
        if (s2_first_reg) acc_reg <= AW'(s2_sq_reg);
        else              acc_reg <= acc_reg + AW'(s2_sq_reg);
      end
    end
  end

  // Round half up, divide by window length, drop the extra QP fraction bits, then clip
  always_comb begin
    rnd_sum   = {1'b0, acc_reg} + RND_HALF;
    rnd_shift = rnd_sum >> SH;
    res_sat   = |rnd_shift[AW:WIDTH];
    res_val   = res_sat ? {WIDTH{1'b1}} : rnd_shift[WIDTH-1:0];
    load_ok   = !mse_valid_reg || mse_ready;
  end

  // One-entry output buffer; a result that cannot be loaded is dropped and flagged
  always_ff @(posedge clk) begin
    if (reset) begin
      mse_out_reg   <= '0;
      mse_sat_reg   <= 1'b0;
      mse_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (done_reg && load_ok) begin
        mse_out_reg   <= res_val;
        mse_sat_reg   <= res_sat;
        mse_valid_reg <= 1'b1;
      end else if (mse_valid_reg && mse_ready) begin
        mse_valid_reg <= 1'b0;
      end
      if (done_reg && !load_ok) overrun_reg <= 1'b1;
      else if (start_accept)    overrun_reg <= 1'b0;
    end
  end

  assign mse_out   = mse_out_reg;
  assign mse_sat   = mse_sat_reg;
  assign mse_valid = mse_valid_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_tflaf_mse_monitor.sv
// Directed testbench for tflaf_mse_monitor (WIDTH=16, QP=12, LOG2_WIN=8, SKIP=8).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_tflaf_mse_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        err_valid;
  logic [15:0] error_in;
  logic [15:0] mse_out;
  logic        mse_sat;
  logic        mse_valid;
  logic        mse_ready;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int passed = 0;
  int edge_num = 0;
  logic valid_prev = 1'b0;

  logic [16:0] xfer_q[$];   // {sat, value} of every handshake transfer
  int          rise_q[$];   // edge number of every mse_valid rise
  int          acc_edge[0:2047];

  tflaf_mse_monitor #(.WIDTH(16), .QP(12), .LOG2_WIN(8), .SKIP(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .err_valid (err_valid),
    .error_in  (error_in),
    .mse_out   (mse_out),
    .mse_sat   (mse_sat),
    .mse_valid (mse_valid),
    .mse_ready (mse_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
      $display("check %-22s got 0x%0h expected 0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-22s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: log a transfer happening at the coming edge, then observe after it
  task automatic tick();
    if (!reset && mse_valid && mse_ready) xfer_q.push_back({mse_sat, mse_out});
    @(posedge clk);
    edge_num++;
    @(negedge clk);
    if (mse_valid && !valid_prev) rise_q.push_back(edge_num);
    valid_prev = mse_valid;
  endtask

  function automatic logic [16:0] xfer_at(input int i);
    if (i < xfer_q.size()) return xfer_q[i];
    return 17'h1ffff;
  endfunction

  function automatic int rise_at(input int i);
    if (i < rise_q.size()) return rise_q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    xfer_q.delete();
    rise_q.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; start = 1'b0; stop = 1'b0; err_valid = 1'b0; error_in = '0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    err_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] val, input int n);
    err_valid = 1'b1;
    error_in  = val;
    repeat (n) tick();
    err_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    err_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int n;
    int k;
    mse_ready = 1'b1;

    // Reset values
    do_reset(3);
    check_eq("rst_mse_out", mse_out, 0);
    check_eq("rst_mse_sat", mse_sat, 0);
    check_eq("rst_mse_valid", mse_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);

    // Constant 0.5: results of 1024 every 256 cycles, then stop mid-window
    clear_logs();
    pulse_start();
    check_eq("busy_after_start", busy, 1);
    n = 0;
    err_valid = 1'b1;
    error_in  = 16'd2048;
    for (int cyc = 0; cyc < 2000 && busy; cyc++) begin
      n++;
      stop = (n == 620);
      tick();
      acc_edge[n] = edge_num;
      if (n == 775) check_eq("busy_before_last", busy, 1);
    end
    stop = 1'b0;
    err_valid = 1'b0;
    check_eq("stop_final_sample", n, 776);
    check_eq("busy_after_stop", busy, 0);
    idle(20);
    check_eq("half_result_count", xfer_q.size(), 3);
    check_eq("half_result0", xfer_at(0), {1'b0, 16'd1024});
    check_eq("half_result1", xfer_at(1), {1'b0, 16'd1024});
    check_eq("half_result2", xfer_at(2), {1'b0, 16'd1024});
    check_eq("half_rise0_latency", rise_at(0), acc_edge[264] + 3);
    check_eq("half_rise1_spacing", rise_at(1) - rise_at(0), 256);
    check_eq("stop_rise_latency", rise_at(2), acc_edge[776] + 3);

    // Alternating +/-1.0 at half rate: 4096 every 512 cycles
    do_reset(2);
    clear_logs();
    pulse_start();
    k = 0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      err_valid = (cyc % 2 == 0);
      error_in  = (k % 2 == 0) ? 16'h1000 : 16'hF000;
      if (err_valid) k++;
      tick();
    end
    err_valid = 1'b0;
    check_eq("alt_result_count", xfer_q.size(), 2);
    check_eq("alt_result0", xfer_at(0), {1'b0, 16'd4096});
    check_eq("alt_result1", xfer_at(1), {1'b0, 16'd4096});
    check_eq("alt_spacing", rise_at(1) - rise_at(0), 512);

    // Most negative input: every window saturates
    do_reset(2);
    clear_logs();
    pulse_start();
    feed(16'h8000, 8 + 512);
    idle(5);
    check_eq("sat_result_count", xfer_q.size(), 2);
    check_eq("sat_result0", xfer_at(0), {1'b1, 16'hFFFF});
    check_eq("sat_result1", xfer_at(1), {1'b1, 16'hFFFF});

    // Large skipped samples must not reach the accumulator
    do_reset(2);
    clear_logs();
    pulse_start();
    feed(16'h7FFF, 8);
    feed(16'h0000, 256);
    idle(5);
    check_eq("skip_result_count", xfer_q.size(), 1);
    check_eq("skip_result0", xfer_at(0), {1'b0, 16'd0});

    // Backpressure: first result held, second dropped, overrun until next start
    do_reset(2);
    clear_logs();
    mse_ready = 1'b0;
    pulse_start();
    feed(16'd2048, 8 + 256);
    feed(16'd4096, 256);
    idle(5);
    check_eq("bp_valid_held", mse_valid, 1);
    check_eq("bp_value_held", mse_out, 16'd1024);
    check_eq("bp_overrun", overrun, 1);
    idle(4);
    check_eq("bp_value_stable", mse_out, 16'd1024);
    check_eq("bp_no_xfer", xfer_q.size(), 0);
    mse_ready = 1'b1;
    tick();
    check_eq("bp_valid_cleared", mse_valid, 0);
    check_eq("bp_xfer_count", xfer_q.size(), 1);
    check_eq("bp_xfer_value", xfer_at(0), {1'b0, 16'd1024});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    feed(16'd0, 256);
    check_eq("bp_busy_after_stop", busy, 0);
    idle(5);
    check_eq("bp_final_count", xfer_q.size(), 2);
    check_eq("bp_overrun_idle", overrun, 1);
    pulse_start();
    check_eq("bp_overrun_cleared", overrun, 0);

    // Reset mid-window discards the partial window and the buffered result
    do_reset(2);
    clear_logs();
    mse_ready = 1'b0;
    pulse_start();
    feed(16'd2048, 8 + 256 + 99);
    check_eq("mid_buffered", mse_valid, 1);
    reset = 1'b1;
    err_valid = 1'b1;
    tick();
    check_eq("mid_rst_valid", mse_valid, 0);
    check_eq("mid_rst_out", mse_out, 0);
    check_eq("mid_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    err_valid = 1'b0;
    mse_ready = 1'b1;
    idle(10);
    check_eq("mid_no_result", xfer_q.size(), 0);
    pulse_start();
    feed(16'd4096, 8 + 256);
    idle(5);
    check_eq("mid_next_count", xfer_q.size(), 1);
    check_eq("mid_next_result", xfer_at(0), {1'b0, 16'd4096});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
